// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT butterfly control-word sequencer: defaults,
// control-word layout, FSM states and the zeta-table generator.
package ntt_pkg;

  localparam int          N_DEF      = 256;
  localparam int          ADDR_W_DEF = 8;
  localparam int          TW_W_DEF   = 12;
  localparam int          Q_DEF      = 3329;
  localparam logic [15:0] HDR_DEF    = 16'h02f6;
  localparam int          ZETA_ROOT  = 17;
  localparam int          MONT_SHIFT = 16;

  // Control-word layout, MSB first: [63:48] hdr, [47:40] idx, [39:32] idx_b,
  // [31:16] tw, [15:8] a, [7:0] b.
  typedef struct packed {
    logic [15:0] hdr;
    logic [7:0]  idx;
    logic [7:0]  idx_b;
    logic [15:0] tw;
    logic [7:0]  a;
    logic [7:0]  b;
  } ctrl_word_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Twiddle for table slot k: ZETA_ROOT^brv(k) mod q, kept in the Montgomery
  // domain (scaled by 2^16 mod q) because the butterfly multiplier expects it.
  function automatic int zeta_mont(input int k, input int bits, input int q);
    int r;
    int p;
    int base;
    int e;
    r = 0;
    for (int j = 0; j < bits; j++) begin
      r = (r << 1) | ((k >> j) & 1);
    end
    p    = 1;
    base = ZETA_ROOT % q;
    e    = r;
    while (e != 0) begin
      if ((e & 1) != 0) p = (p * base) % q;
      base = (base * base) % q;
      e    = e >> 1;
    end
    return (p * ((1 << MONT_SHIFT) % q)) % q;
  endfunction

endpackage

// File: rtl/ntt_zeta_rom.sv
// Synchronous N/2-entry twiddle ROM; contents are elaboration-time constants
// produced by ntt_pkg::zeta_mont, one registered read per enabled cycle.
module ntt_zeta_rom
  import ntt_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int TW_W   = TW_W_DEF,
  parameter int Q      = Q_DEF
) (
  input  logic              clk,
  input  logic              srst_n,
  input  logic              i_rd_en,
  input  logic [ADDR_W-2:0] i_addr,
  output logic [TW_W-1:0]   o_data
);

  localparam int DEPTH = N / 2;

  logic [TW_W-1:0] w_rom [DEPTH];
  logic [TW_W-1:0] r_data;

  for (genvar j = 0; j < DEPTH; j++) begin : g_rom
    assign w_rom[j] = TW_W'(zeta_mont(j, ADDR_W - 1, Q));
  end

  // NOTE: only the read register is reset; the table itself is constant and
  // needs none, which lets it map onto a ROM macro or LUTs.
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      r_data <= '0;
    end else if (i_rd_en) begin
      r_data <= w_rom[i_addr];
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/ntt_ctrl_seq.sv
// Run-time NTT butterfly control-word generator: index stage -> zeta ROM ->
// output register on a valid/ready stream. Macro NTT_INV_EN enables inverse.
module ntt_ctrl_seq
  import ntt_pkg::*;
#(
  parameter int          N      = N_DEF,
  parameter int          ADDR_W = ADDR_W_DEF,
  parameter int          TW_W   = TW_W_DEF,
  parameter int          Q      = Q_DEF,
  parameter logic [15:0] HDR    = HDR_DEF
) (
  input  logic        clk,
  input  logic        srst_n,
  input  logic        start,
  input  logic [2:0]  stage,
  input  logic        inv,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_word,
  output logic        out_last,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int            IW        = ADDR_W - 1;
  localparam logic [IW-1:0] IDX_MAX   = {IW{1'b1}};
  localparam logic [IW-1:0] IDX_ONE   = IW'(1);
  localparam logic [IW-1:0] IDX_TWO   = IW'(2);
  localparam logic [2:0]    MAX_STAGE = 3'(ADDR_W - 2);
  localparam logic [2:0]    IW3       = 3'(IW);

  state_t              r_state;
  logic [2:0]          r_s;
  logic [IW-1:0]       r_idx;
  logic                r_idx_vld;
  logic                r_p1_vld;
  logic [IW-1:0]       r_p1_i;
  logic [ADDR_W-1:0]   r_p1_a;
  logic [ADDR_W-1:0]   r_p1_b;
  logic                r_out_valid;
  logic [63:0]         r_out_word;
  logic                r_out_last;
  logic                r_busy;
  logic                r_done;
  logic                r_err;

  logic                w_adv;
  logic                w_last_hs;
  logic                w_start_ok;
  logic                w_rom_en;
  logic [IW-1:0]       w_len_m1;
  logic [IW-1:0]       w_g;
  logic [IW-1:0]       w_k;
  logic [ADDR_W-1:0]   w_a;
  logic [ADDR_W-1:0]   w_b;
  logic [TW_W-1:0]     w_zeta;
  logic [TW_W-1:0]     w_tw;
  ctrl_word_t          w_word;

  // The whole pipeline moves together whenever the output slot is free.
  assign w_adv      = !r_out_valid || out_ready;
  assign w_last_hs  = r_out_valid && out_ready && r_out_last;
  assign w_start_ok = (r_state == ST_IDLE) && start && (stage <= MAX_STAGE);
  assign w_rom_en   = w_adv && r_idx_vld;

  // len = 2^(IW-s): g*len is i with the low bits cleared, o keeps them.
  assign w_len_m1 = IDX_MAX >> r_s;
  assign w_g      = r_idx >> (IW3 - r_s);
  assign w_a      = {r_idx & ~w_len_m1, 1'b0} + {1'b0, r_idx & w_len_m1};
  assign w_b      = w_a + {1'b0, w_len_m1} + ADDR_W'(1);

`ifdef NTT_INV_EN
  logic r_inv;

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      r_inv <= 1'b0;
    end else if (w_start_ok) begin
      r_inv <= inv;
    end
  end

  // Modular wrap in IW bits gives 2^(s+1)-1-g even for the last stage.
  assign w_k  = r_inv ? (IDX_TWO << r_s) - IDX_ONE - w_g : (IDX_ONE << r_s) + w_g;
  assign w_tw = r_inv ? TW_W'(Q) - w_zeta : w_zeta;
`else
  logic w_unused_inv;

  assign w_unused_inv = inv;
  assign w_k          = (IDX_ONE << r_s) + w_g;
  assign w_tw         = w_zeta;
`endif

  ntt_zeta_rom #(
    .N      (N),
    .ADDR_W (ADDR_W),
    .TW_W   (TW_W),
    .Q      (Q)
  ) u_zeta_rom (
    .clk     (clk),
    .srst_n  (srst_n),
    .i_rd_en (w_rom_en),
    .i_addr  (w_k),
    .o_data  (w_zeta)
  );

  // NOTE: every field gets a value before any branch, so no latch is inferred.
  always_comb begin
    w_word       = '0;
    w_word.hdr   = HDR;
    w_word.idx   = 8'(r_p1_i);
    w_word.idx_b = 8'({1'b1, r_p1_i});
    w_word.tw    = 16'(w_tw);
    w_word.a     = 8'(r_p1_a);
    w_word.b     = 8'(r_p1_b);
  end

  // NOTE: all state updates here are non-blocking so every register samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      r_state     <= ST_IDLE;
      r_s         <= '0;
      r_idx       <= '0;
      r_idx_vld   <= 1'b0;
      r_p1_vld    <= 1'b0;
      r_p1_i      <= '0;
      r_p1_a      <= '0;
      r_p1_b      <= '0;
      r_out_valid <= 1'b0;
      r_out_word  <= '0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_start_ok) begin
            r_state   <= ST_RUN;
            r_s       <= stage;
            r_idx     <= '0;
            r_idx_vld <= 1'b1;
            r_busy    <= 1'b1;
          end else if (start) begin
            r_err <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_last_hs) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_adv) begin
        if (r_idx_vld) begin
          if (r_idx == IDX_MAX) begin
            r_idx_vld <= 1'b0;
          end else begin
            r_idx <= r_idx + IDX_ONE;
          end
          r_p1_i <= r_idx;
          r_p1_a <= w_a;
          r_p1_b <= w_b;
        end
        r_p1_vld    <= r_idx_vld;
        r_out_valid <= r_p1_vld;
        r_out_last  <= r_p1_vld && (r_p1_i == IDX_MAX);
        if (r_p1_vld) begin
          r_out_word <= w_word;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_word  = r_out_word;
  assign out_last  = r_out_last;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: doc/ntt_ctrl_seq.md
Name: ntt_ctrl_seq

Overview:
- Parametrised run-time generator of NTT butterfly control words; replaces the per-stage fixed control ROMs.
- One instance covers every stage (0..log2(N)-2) and forward or inverse transform; emits N/2 words per stage on a valid/ready stream.
- Sits between the NTT top-level controller and the butterfly datapath/coefficient RAM address logic.
- Twiddles come from an internal synchronous zeta ROM sub-module.

Parameters:
- N, 256, polynomial length; power of two, 16..256.
- ADDR_W, 8, coefficient address width; log2(N).
- TW_W, 12, twiddle value width.
- Q, 3329, modulus; for inverse twiddle negation.
- HDR, 16'h02f6, constant header placed in word[63:48].

Ports:
- clk  in  1  clock.
- srst_n  in  1  synchronous reset, active-low.
- start  in  1  one-cycle request to begin a stage; sampled only in IDLE.
- stage  in  3  stage number s, sampled with start; legal 0..log2(N)-2.
- inv  in  1  1 = inverse transform, sampled with start.
- out_valid  out  1  word valid.
- out_ready  in  1  downstream accepts word.
- out_word  out  64  control word.
- out_last  out  1  high with final word (i = N/2-1).
- busy  out  1  high from accepted start until last word accepted.
- done  out  1  one-cycle pulse the cycle after last word accepted.
- err  out  1  one-cycle pulse when start carries illegal stage.

Behaviour:
- Reset (srst_n=0 at clk edge): FSM=IDLE, counter=0, out_valid=0, out_word=0, out_last=0, busy=0, done=0, err=0. Reset mid-stage aborts silently (no done).
- FSM: IDLE -> RUN on start with legal stage; IDLE stays, err=1 for one cycle on illegal stage. RUN -> IDLE when the last word handshakes (out_valid&out_ready, out_last=1); done pulses next cycle.
- start while busy: ignored, no err.
- Per index i (0..N/2-1): len = (N/2)>>s; g = i/len; o = i%len; a = 2*g*len + o; b = a + len.
- Forward twiddle index k = (1<<s) + g; inverse k = (2<<s) - 1 - g.
- Word: [63:48]=HDR; [47:40]=i zero-extended; [39:32]=i + N/2 (bank-B tag); [31:16]=twiddle zero-extended; [15:8]=a; [7:0]=b. Fields narrower than 8 bits zero-extended.
- Twiddle: forward = zeta[k]; inverse = Q - zeta[k] (zeta[k] never 0).
- Pipeline: index stage -> ROM read (1 cycle, synchronous) -> output register. First out_valid two cycles after accepted start.
- Throughput one word/cycle while out_ready=1. Backpressure: out_ready=0 holds out_word/out_last stable, counter and ROM address frozen; no word dropped or duplicated.
- out_valid never deasserts without a handshake during RUN.
- Counter width log2(N)-1; no wrap — stops at N/2-1.
- Example: s=log2(N)-2 forward, N=256 reproduces 02f6008008b20002-style words (len=2, k=64+i/2).

Optional Feature:
- NTT_INV_EN: defined -> inv honoured as above. Undefined -> inverse logic and Q subtractor removed; inv ignored, all stages forward; output identical for inv=0.

Decomposition:
- Package ntt_pkg: HDR, Q, N defaults, word field bit positions, FSM state enum (IDLE, RUN).
- Sub-module ntt_zeta_rom: N/2 x TW_W synchronous ROM, zeta[k] = 17^brv(k) mod Q (brv over log2(N)-1 bits), clk/srst_n, read enable, output zeroed on reset.

Test Plan:
- Reset then start, s=6, inv=0, out_ready=1 -> 128 words; word0=64'h02f6008008b20002, word1=64'h02f6018108b20103; out_last on word 127; done pulse one cycle after.
- s=0 forward -> word0 a=0, b=128, twiddle=zeta[1]; word127 a=127, b=255; all twiddles equal.
- s=6 inv=1 (NTT_INV_EN defined) -> word0 twiddle = 3329 - zeta[127]; without macro -> identical to forward stream.
- Random out_ready toggling, s=3 -> collected stream identical to uninterrupted run; outputs stable while stalled.
- start with stage=7 -> err pulse, busy stays 0, no out_valid; start during RUN -> ignored.
- srst_n=0 at word 40 of stage 2 -> all outputs 0 next cycle, no done; fresh start yields full 128-word stream.
